spm_arbiter: RTL
================

SPM_ARBITER -- requirements
Module: spm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 30, SHALL set the word-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 m0_addr/m0_as_/m0_rw/m0_wr_data  input  ADDR_W/1/1/DATA_W  SHALL be the master 0 (instruction fetch) request; m0_as_ is active-low.
REQ-006 m0_rd_data  output  DATA_W  SHALL carry master 0 read data; m0_rdy  output  1  SHALL be the master 0 completion strobe, active-high.
REQ-007 m1_addr/m1_as_/m1_rw/m1_wr_data/m1_rd_data/m1_rdy SHALL be identical to the master 0 signals, for master 1 (data memory access).
REQ-008 spm_addr  output  ADDR_W, spm_as_  output  1 (active-low), spm_rw  output  1, spm_wr_data  output  DATA_W, spm_rd_data  input  DATA_W SHALL be the single-port SPM access port.

Function
REQ-009 A master requests by driving as_ low and SHALL hold addr, rw and wr_data stable until the cycle its rdy is high.
REQ-010 The SPM samples the access on the clock edge ending the grant cycle and returns read data in the following cycle; the arbiter SHALL NOT register read data.
REQ-011 FSM states SHALL be IDLE, ACK0 and ACK1; ACKk means that master k was granted in the previous cycle.
REQ-012 Grant SHALL be combinational each cycle over the eligible requesters, where master k is ineligible while in ACKk.
REQ-013 When a master is granted, spm_addr/spm_rw/spm_wr_data SHALL mux that master's signals and spm_as_ SHALL be low; with no grant, spm_as_ SHALL be high and the mux SHALL select master 0.
REQ-014 Next state SHALL be ACKk when master k is granted, else IDLE.
REQ-015 In ACKk, mk_rdy SHALL be 1; if the latched access was a read, mk_rd_data SHALL be spm_rd_data, else 0.
REQ-016 Outside ACKk, mk_rdy and mk_rd_data SHALL be 0.
REQ-017 Latency SHALL be exactly 1 cycle from grant to rdy for reads and writes alike.
REQ-018 In ACKk, the other master SHALL be grantable in the same cycle (pipelined), sustaining one access per cycle under alternating load.
REQ-019 A master de-asserting as_ before rdy SHALL be an illegal stimulus; the arbiter SHALL still complete the granted access.
REQ-020 A 1-bit last_grant register SHALL record the most recently granted master.

Reset
REQ-021 On reset high, regardless of clk: state=IDLE, last_grant=0, spm_as_=1, m0_rdy=m1_rdy=0, m0_rd_data=m1_rd_data=0.
REQ-022 Reset asserted mid-access SHALL abort the access; no rdy SHALL be issued for it after reset releases.
REQ-023 The first cycle after reset release SHALL arbitrate normally.

Configuration
REQ-024 Macro SPM_ARB_RR_EN defined: when both masters are eligible, the master other than last_grant SHALL win (round-robin).
REQ-025 Macro SPM_ARB_RR_EN undefined: when both masters are eligible, master 1 SHALL always win (fixed priority); last_grant is still maintained.
REQ-026 The macro SHALL affect only the tie-break rule; timing and interface SHALL be identical in both builds.

Verification
REQ-027 m0 read of addr 0x10, SPM word 0xDEADBEEF -> spm_as_=0 and spm_addr=0x10 in cycle N; m0_rdy=1 and m0_rd_data=0xDEADBEEF in cycle N+1.
REQ-028 m1 write of 0x12345678 to 0x20 -> spm_rw=write and spm_wr_data=0x12345678 in cycle N; m1_rdy=1 and m1_rd_data=0 in cycle N+1.
REQ-029 Both masters request in the same cycle after reset -> RR build: m1 granted first, m0 next cycle; non-RR build: m1 granted first, m0 granted in m1's ACK cycle.
REQ-030 Both masters request continuously for 6 cycles -> grants alternate m1,m0,m1,m0,... with one rdy every cycle and no idle SPM cycle.
REQ-031 Reset pulsed while in ACK0 -> m0_rdy=0 during and after reset, spm_as_=1, and state=IDLE.
REQ-032 No requests for 5 cycles -> spm_as_=1, both rdy=0, both rd_data=0 throughout.

Source files
------------

// File: rtl/spm_arbiter.sv
// Two-master arbiter for a single-port scratchpad memory (rw: 1 = read, 0 = write).
// Define SPM_ARB_RR_EN for a round-robin tie-break; otherwise master 1 wins ties.
module spm_arbiter #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_as_,
  input  logic              m0_rw,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic              m0_rdy,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_as_,
  input  logic              m1_rw,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              m1_rdy,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data
);

  localparam logic RwRead = 1'b1;

  typedef enum logic [1:0] {StIdle, StAck0, StAck1} state_e;

  state_e state_q;
  logic   last_grant_q;
  logic   ack_read_q;
  logic   elig0, elig1, tie_pick0, grant0, grant1;

  // A master in its ACK cycle is still holding the finished request, so it sits out.
  always_comb begin
    elig0 = !reset && !m0_as_ && (state_q != StAck0);
    elig1 = !reset && !m1_as_ && (state_q != StAck1);
`ifdef SPM_ARB_RR_EN
    tie_pick0 = last_grant_q;
`else
    tie_pick0 = 1'b0;
`endif
    grant0 = elig0 && (!elig1 || tie_pick0);
    grant1 = elig1 && !grant0;
  end

  always_comb begin
    if (grant1) begin
      spm_addr    = m1_addr;
      spm_rw      = m1_rw;
      spm_wr_data = m1_wr_data;
    end else begin
      spm_addr    = m0_addr;
      spm_rw      = m0_rw;
      spm_wr_data = m0_wr_data;
    end
    spm_as_ = !(grant0 || grant1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b0;
      ack_read_q   <= 1'b0;
    end else if (grant0) begin
      state_q      <= StAck0;
      last_grant_q <= 1'b0;
      ack_read_q   <= (m0_rw == RwRead);
    end else if (grant1) begin
      state_q      <= StAck1;
      last_grant_q <= 1'b1;
      ack_read_q   <= (m1_rw == RwRead);
    end else begin
      state_q      <= StIdle;
    end
  end

  // Read data comes straight from the SPM in the ACK cycle; writes return zero.
  always_comb begin
    m0_rdy     = (state_q == StAck0);
    m1_rdy     = (state_q == StAck1);
    m0_rd_data = (m0_rdy && ack_read_q) ? spm_rd_data : '0;
    m1_rd_data = (m1_rdy && ack_read_q) ? spm_rd_data : '0;
  end

endmodule
